// File: rtl/wb_trap_unit_pkg.sv
// Shared constants and types for the write-back trap unit: CSR addresses,
// mcause codes, exception vector bit positions, CSR op encodings and FSM states.
package trap_pkg;

   localparam logic [11:0] CSR_MSTATUS  = 12'h300;
   localparam logic [11:0] CSR_MIE      = 12'h304;
   localparam logic [11:0] CSR_MTVEC    = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH = 12'h340;
   localparam logic [11:0] CSR_MEPC     = 12'h341;
   localparam logic [11:0] CSR_MCAUSE   = 12'h342;
   localparam logic [11:0] CSR_MTVAL    = 12'h343;
   localparam logic [11:0] CSR_MIP      = 12'h344;

   localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
   localparam logic [31:0] CAUSE_LOAD    = 32'd5;
   localparam logic [31:0] CAUSE_STORE   = 32'd7;
   localparam logic [31:0] CAUSE_ECALL   = 32'd11;
   localparam logic [31:0] CAUSE_EXT_INT = 32'h8000_000B;

   localparam int EXP_ILLEGAL = 3;
   localparam int EXP_ECALL   = 2;
   localparam int EXP_LOAD    = 1;
   localparam int EXP_STORE   = 0;

   typedef enum logic [1:0] {
      CSR_NONE  = 2'b00,
      CSR_WRITE = 2'b01,
      CSR_SET   = 2'b10,
      CSR_CLEAR = 2'b11
   } csr_op_e;

   typedef enum logic {
      S_IDLE     = 1'b0,
      S_REDIRECT = 1'b1
   } state_e;

   function automatic logic [31:0] csr_apply(input csr_op_e op, input logic [31:0] old,
                                             input logic [31:0] wdata);
      case (op)
         CSR_WRITE: csr_apply = wdata;
         CSR_SET:   csr_apply = old | wdata;
         CSR_CLEAR: csr_apply = old & ~wdata;
         default:   csr_apply = old;
      endcase
   endfunction

endpackage

// File: rtl/wb_trap_unit_if.sv
// MEM/WB exception/CSR fields into the trap unit and its flush/redirect results.
interface wb_trap_if;
   logic        EN;
   logic [31:0] PCurrent_WB;
   logic [31:0] IR_WB;
   logic [31:0] ALUO_WB;
   logic [3:0]  exp_vector_WB;
   logic        mret_WB;
   logic        isFlushed;
   logic [1:0]  csr_op_WB;
   logic [11:0] csr_addr_WB;
   logic [31:0] csr_wdata_WB;
   logic [31:0] csr_rdata;
   logic        wb_kill;
   logic        flush_all;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   modport master (
      output EN, PCurrent_WB, IR_WB, ALUO_WB, exp_vector_WB, mret_WB, isFlushed,
             csr_op_WB, csr_addr_WB, csr_wdata_WB,
      input  csr_rdata, wb_kill, flush_all, redirect_valid, redirect_pc
   );

   modport slave (
      input  EN, PCurrent_WB, IR_WB, ALUO_WB, exp_vector_WB, mret_WB, isFlushed,
             csr_op_WB, csr_addr_WB, csr_wdata_WB,
      output csr_rdata, wb_kill, flush_all, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/wb_trap_unit_csr_file.sv
// Machine-mode CSR storage: write masks, read mux, trap/mret side effects and
// the ext_int synchroniser feeding mip.MEIP.
module m_csr_file
   import trap_pkg::*;
#(
   parameter logic [31:0] MTVEC_RESET     = 32'h0000_0100,
   parameter int          INT_SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        ext_int,
   input  logic        trap_take,
   input  logic [31:0] trap_epc,
   input  logic [31:0] trap_cause,
   input  logic [31:0] trap_tval,
   input  logic        mret_take,
   input  logic        csr_we,
   input  csr_op_e     csr_op,
   input  logic [11:0] csr_addr,
   input  logic [31:0] csr_wdata,
   output logic [31:0] csr_rdata,
   output logic [31:0] mtvec,
   output logic [31:0] mepc,
   output logic        irq_pending
);

   logic                       st_mie;
   logic                       st_mpie;
   logic                       meie;
   logic [31:0]                mscratch;
   logic [31:0]                mcause;
   logic [31:0]                mtval;
   logic [INT_SYNC_STAGES-1:0] int_sync;
   logic                       meip;
   logic [31:0]                wval;

   assign meip        = int_sync[INT_SYNC_STAGES-1];
   assign irq_pending = st_mie & meie & meip;

   always_comb begin
      case (csr_addr)
         CSR_MSTATUS:  csr_rdata = {19'b0, 2'b11, 3'b0, st_mpie, 3'b0, st_mie, 3'b0};
         CSR_MIE:      csr_rdata = {20'b0, meie, 11'b0};
         CSR_MTVEC:    csr_rdata = mtvec;
         CSR_MSCRATCH: csr_rdata = mscratch;
         CSR_MEPC:     csr_rdata = mepc;
         CSR_MCAUSE:   csr_rdata = mcause;
         CSR_MTVAL:    csr_rdata = mtval;
         CSR_MIP:      csr_rdata = {20'b0, meip, 11'b0};
         default:      csr_rdata = 32'b0;
      endcase
   end

   // Read-modify-write starts from the visible value; masks are applied on store.
   assign wval = csr_apply(csr_op, csr_rdata, csr_wdata);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_mie   <= 1'b0;
         st_mpie  <= 1'b0;
         meie     <= 1'b0;
         mtvec    <= {MTVEC_RESET[31:2], 2'b00};
         mscratch <= 32'b0;
         mepc     <= 32'b0;
         mcause   <= 32'b0;
         mtval    <= 32'b0;
         int_sync <= '0;
      end else if (en) begin
         int_sync <= {int_sync[INT_SYNC_STAGES-2:0], ext_int};
         if (trap_take) begin
            mepc    <= {trap_epc[31:2], 2'b00};
            mcause  <= trap_cause;
            mtval   <= trap_tval;
            st_mpie <= st_mie;
            st_mie  <= 1'b0;
         end else if (mret_take) begin
            st_mie  <= st_mpie;
            st_mpie <= 1'b1;
         end else if (csr_we) begin
            case (csr_addr)
               CSR_MSTATUS: begin
                  st_mie  <= wval[3];
                  st_mpie <= wval[7];
               end
               CSR_MIE:      meie     <= wval[11];
               CSR_MTVEC:    mtvec    <= {wval[31:2], 2'b00};
               CSR_MSCRATCH: mscratch <= wval;
               CSR_MEPC:     mepc     <= {wval[31:2], 2'b00};
               CSR_MCAUSE:   mcause   <= wval;
               CSR_MTVAL:    mtval    <= wval;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: rtl/wb_trap_unit.sv
// Write-back trap resolution: picks exception / interrupt / mret / CSR op for
// the WB slot and issues a registered one-cycle flush and PC redirect.
//
// state      | meaning
// S_IDLE     | WB slot may be taken; flush/redirect outputs low
// S_REDIRECT | one cycle of flush_all/redirect_valid high; WB inputs ignored
module wb_trap_unit
   import trap_pkg::*;
#(
   parameter logic [31:0] MTVEC_RESET     = 32'h0000_0100,
   parameter int          INT_SYNC_STAGES = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ext_int,
   wb_trap_if.slave     bus
);

   state_e      state;
   csr_op_e     csr_op;
   logic        slot_valid;
   logic        exc;
   logic        irq_pending;
   logic        take_trap;
   logic        take_mret;
   logic        csr_we;
   logic [31:0] trap_cause;
   logic [31:0] trap_tval;
   logic [31:0] mtvec;
   logic [31:0] mepc;
   logic        flush_q;
   logic        redirect_q;
   logic [31:0] redirect_pc_q;

   assign csr_op     = csr_op_e'(bus.csr_op_WB);
   assign slot_valid = bus.EN && !bus.isFlushed && (state == S_IDLE);
   assign exc        = |bus.exp_vector_WB;
   assign take_trap  = slot_valid && (exc || irq_pending);
   assign take_mret  = slot_valid && !take_trap && bus.mret_WB;
   assign csr_we     = slot_valid && !take_trap && !bus.mret_WB && (csr_op != CSR_NONE);

   always_comb begin
      trap_cause = CAUSE_EXT_INT;
      trap_tval  = 32'b0;
      if (bus.exp_vector_WB[EXP_ILLEGAL]) begin
         trap_cause = CAUSE_ILLEGAL;
         trap_tval  = bus.IR_WB;
      end else if (bus.exp_vector_WB[EXP_ECALL]) begin
         trap_cause = CAUSE_ECALL;
      end else if (bus.exp_vector_WB[EXP_LOAD]) begin
         trap_cause = CAUSE_LOAD;
         trap_tval  = bus.ALUO_WB;
      end else if (bus.exp_vector_WB[EXP_STORE]) begin
         trap_cause = CAUSE_STORE;
         trap_tval  = bus.ALUO_WB;
      end
   end

   m_csr_file #(
      .MTVEC_RESET     (MTVEC_RESET),
      .INT_SYNC_STAGES (INT_SYNC_STAGES)
   ) u_csr (
      .clk         (clk),
      .rst         (rst),
      .en          (bus.EN),
      .ext_int     (ext_int),
      .trap_take   (take_trap),
      .trap_epc    (bus.PCurrent_WB),
      .trap_cause  (trap_cause),
      .trap_tval   (trap_tval),
      .mret_take   (take_mret),
      .csr_we      (csr_we),
      .csr_op      (csr_op),
      .csr_addr    (bus.csr_addr_WB),
      .csr_wdata   (bus.csr_wdata_WB),
      .csr_rdata   (bus.csr_rdata),
      .mtvec       (mtvec),
      .mepc        (mepc),
      .irq_pending (irq_pending)
   );

   // mtvec/mepc are sampled before this edge's CSR update lands.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= S_IDLE;
         flush_q       <= 1'b0;
         redirect_q    <= 1'b0;
         redirect_pc_q <= 32'b0;
      end else if (bus.EN) begin
         case (state)
            S_IDLE: begin
               if (take_trap || take_mret) begin
                  state         <= S_REDIRECT;
                  flush_q       <= 1'b1;
                  redirect_q    <= 1'b1;
                  redirect_pc_q <= take_trap ? mtvec : mepc;
               end
            end
            S_REDIRECT: begin
               state         <= S_IDLE;
               flush_q       <= 1'b0;
               redirect_q    <= 1'b0;
               redirect_pc_q <= 32'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.wb_kill        = take_trap;
   assign bus.flush_all      = flush_q;
   assign bus.redirect_valid = redirect_q;
   assign bus.redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_wb_trap_unit.sv
// Bench for wb_trap_unit: architectural CSR/trap model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_wb_trap_unit;

   localparam int SYNC = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ext_int = 1'b0;
   int   total = 0;
   int   bad = 0;

   wb_trap_if bus ();

   wb_trap_unit #(.MTVEC_RESET(32'h0000_0100), .INT_SYNC_STAGES(SYNC)) dut (
      .clk     (clk),
      .rst     (rst),
      .ext_int (ext_int),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // architectural model state
   logic        m_mie, m_mpie, m_meie, m_redir;
   logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_rpc;
   bit          hist [SYNC];

   function automatic logic m_sync();
      return hist[SYNC-1];
   endfunction

   function automatic logic [31:0] m_read(input logic [11:0] a);
      case (a)
         12'h300: return 32'h1800 | (m_mpie ? 32'h80 : 32'h0) | (m_mie ? 32'h8 : 32'h0);
         12'h304: return m_meie ? 32'h800 : 32'h0;
         12'h305: return m_mtvec;
         12'h340: return m_mscratch;
         12'h341: return m_mepc;
         12'h342: return m_mcause;
         12'h343: return m_mtval;
         12'h344: return m_sync() ? 32'h800 : 32'h0;
         default: return 32'h0;
      endcase
   endfunction

   task automatic m_write(input logic [11:0] a, input logic [31:0] v);
      case (a)
         12'h300: begin m_mie = v[3]; m_mpie = v[7]; end
         12'h304: m_meie = v[11];
         12'h305: m_mtvec = v & 32'hFFFF_FFFC;
         12'h340: m_mscratch = v;
         12'h341: m_mepc = v & 32'hFFFF_FFFC;
         12'h342: m_mcause = v;
         12'h343: m_mtval = v;
         default: ;
      endcase
   endtask

   task automatic m_reset();
      m_mie = 0; m_mpie = 0; m_meie = 0; m_redir = 0;
      m_mtvec = 32'h100; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0; m_rpc = 0;
      for (int i = 0; i < SYNC; i++) hist[i] = 0;
   endtask

   task automatic m_take(input logic [31:0] cause, input logic [31:0] tval);
      m_mepc   = bus.PCurrent_WB & 32'hFFFF_FFFC;
      m_mcause = cause;
      m_mtval  = tval;
      m_mpie   = m_mie;
      m_mie    = 0;
      m_rpc    = m_mtvec;
      m_redir  = 1;
   endtask

   initial begin
      logic [31:0] old_v, new_v;
      m_reset();
      forever begin
         @(posedge clk or posedge rst);
         if (rst) m_reset();
         else if (bus.EN) begin
            if (m_redir) begin
               m_redir = 0;
               m_rpc   = 0;
            end else if (!bus.isFlushed) begin
               if (bus.exp_vector_WB[3])      m_take(32'd2, bus.IR_WB);
               else if (bus.exp_vector_WB[2]) m_take(32'd11, 32'd0);
               else if (bus.exp_vector_WB[1]) m_take(32'd5, bus.ALUO_WB);
               else if (bus.exp_vector_WB[0]) m_take(32'd7, bus.ALUO_WB);
               else if (m_mie && m_meie && m_sync()) m_take(32'h8000_000B, 32'd0);
               else if (bus.mret_WB) begin
                  m_rpc   = m_mepc;
                  m_redir = 1;
                  m_mie   = m_mpie;
                  m_mpie  = 1;
               end else if (bus.csr_op_WB != 2'b00) begin
                  old_v = m_read(bus.csr_addr_WB);
                  case (bus.csr_op_WB)
                     2'b01:   new_v = bus.csr_wdata_WB;
                     2'b10:   new_v = old_v | bus.csr_wdata_WB;
                     default: new_v = old_v & ~bus.csr_wdata_WB;
                  endcase
                  m_write(bus.csr_addr_WB, new_v);
               end
            end
            for (int i = SYNC - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = ext_int;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // per-cycle comparison against the model
   initial begin
      logic kill_exp;
      forever begin
         @(negedge clk);
         kill_exp = bus.EN && !bus.isFlushed && !m_redir &&
                    ((bus.exp_vector_WB != 4'b0) || (m_mie && m_meie && m_sync()));
         chk("cyc_rdata",    bus.csr_rdata,      m_read(bus.csr_addr_WB));
         chk("cyc_wb_kill",  bus.wb_kill,        kill_exp);
         chk("cyc_flush",    bus.flush_all,      m_redir);
         chk("cyc_redirect", bus.redirect_valid, m_redir);
         chk("cyc_rpc",      bus.redirect_pc,    m_rpc);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: sim time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.EN = 1; bus.isFlushed = 0; bus.exp_vector_WB = 0; bus.mret_WB = 0;
      bus.csr_op_WB = 0; bus.csr_addr_WB = 0; bus.csr_wdata_WB = 0;
      bus.PCurrent_WB = 0; bus.IR_WB = 0; bus.ALUO_WB = 0;
   endtask

   task automatic csr_do(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
      bus.csr_op_WB = op; bus.csr_addr_WB = a; bus.csr_wdata_WB = d;
      tick();
      idle();
   endtask

   task automatic rd(input string name, input logic [11:0] a, input logic [31:0] exp);
      bus.csr_addr_WB = a;
      #1;
      chk(name, bus.csr_rdata, exp);
   endtask

   initial begin
      idle();
      rst = 1;
      repeat (3) tick();
      rst = 0;
      tick();

      // reset state
      rd("rst_mtvec", 12'h305, 32'h100);
      rd("rst_mstatus", 12'h300, 32'h1800);
      chk("rst_flush", bus.flush_all, 0);
      chk("rst_redirect", bus.redirect_valid, 0);

      // ecall trap to relocated mtvec
      csr_do(2'b01, 12'h305, 32'h200);
      bus.exp_vector_WB = 4'b0100; bus.PCurrent_WB = 32'h1000;
      #1 chk("ecall_kill", bus.wb_kill, 1);
      tick(); idle();
      chk("ecall_flush", bus.flush_all, 1);
      chk("ecall_redirect", bus.redirect_valid, 1);
      chk("ecall_rpc", bus.redirect_pc, 32'h200);
      tick();
      chk("ecall_flush_one", bus.flush_all, 0);
      chk("ecall_redirect_one", bus.redirect_valid, 0);
      rd("ecall_mepc", 12'h341, 32'h1000);
      rd("ecall_mcause", 12'h342, 32'd11);
      rd("ecall_mstatus", 12'h300, 32'h1800);

      // illegal beats load fault; same-slot csr write discarded
      bus.exp_vector_WB = 4'b1010; bus.IR_WB = 32'hFFFF_FFFF; bus.ALUO_WB = 32'h55;
      bus.csr_op_WB = 2'b01; bus.csr_addr_WB = 12'h340; bus.csr_wdata_WB = 32'hDEAD;
      tick(); idle();
      tick();
      rd("illegal_mcause", 12'h342, 32'd2);
      rd("illegal_mtval", 12'h343, 32'hFFFF_FFFF);
      rd("illegal_mscratch", 12'h340, 32'h0);

      // set / clear / masks / unmapped / read-only
      csr_do(2'b01, 12'h340, 32'hF0);
      bus.csr_op_WB = 2'b10; bus.csr_addr_WB = 12'h340; bus.csr_wdata_WB = 32'h0F;
      #1 chk("set_prewrite", bus.csr_rdata, 32'hF0);
      tick(); idle();
      rd("set_result", 12'h340, 32'hFF);
      csr_do(2'b11, 12'h340, 32'hF0);
      rd("clear_result", 12'h340, 32'h0F);
      csr_do(2'b01, 12'h305, 32'h203);
      rd("mtvec_mask", 12'h305, 32'h200);
      csr_do(2'b01, 12'h344, 32'hFFFF_FFFF);
      rd("mip_readonly", 12'h344, 32'h0);
      csr_do(2'b01, 12'h123, 32'h1234);
      rd("unmapped", 12'h123, 32'h0);

      // external interrupt
      csr_do(2'b01, 12'h300, 32'h8);
      csr_do(2'b01, 12'h304, 32'h800);
      bus.isFlushed = 1;
      ext_int = 1;
      repeat (3) tick();
      rd("irq_mip", 12'h344, 32'h800);
      bus.isFlushed = 0; bus.PCurrent_WB = 32'h2000;
      #1 chk("irq_kill", bus.wb_kill, 1);
      tick(); idle();
      chk("irq_rpc", bus.redirect_pc, 32'h200);
      chk("irq_flush", bus.flush_all, 1);
      bus.isFlushed = 1;
      ext_int = 0;
      repeat (3) tick();
      bus.isFlushed = 0;
      rd("irq_mepc", 12'h341, 32'h2000);
      rd("irq_mcause", 12'h342, 32'h8000_000B);
      rd("irq_mtval", 12'h343, 32'h0);
      rd("irq_mstatus", 12'h300, 32'h1880);

      // mret
      csr_do(2'b01, 12'h341, 32'h1004);
      bus.mret_WB = 1;
      #1 chk("mret_kill", bus.wb_kill, 0);
      tick(); idle();
      chk("mret_rpc", bus.redirect_pc, 32'h1004);
      chk("mret_redirect", bus.redirect_valid, 1);
      rd("mret_mstatus", 12'h300, 32'h1888);
      tick();

      // flushed bubble ignored
      bus.isFlushed = 1; bus.exp_vector_WB = 4'b0001;
      tick();
      chk("bubble_redirect", bus.redirect_valid, 0);
      chk("bubble_flush", bus.flush_all, 0);
      idle();

      // EN=0 holds the redirect, then async reset mid-redirect
      bus.exp_vector_WB = 4'b0001; bus.PCurrent_WB = 32'h3000; bus.ALUO_WB = 32'h44;
      tick(); idle();
      bus.EN = 0;
      repeat (2) tick();
      chk("hold_flush", bus.flush_all, 1);
      rd("store_mcause", 12'h342, 32'd7);
      rd("store_mtval", 12'h343, 32'h44);
      rst = 1;
      #1;
      chk("arst_flush", bus.flush_all, 0);
      chk("arst_redirect", bus.redirect_valid, 0);
      chk("arst_rpc", bus.redirect_pc, 32'h0);
      tick();
      rst = 0;
      idle();
      tick();
      rd("arst_mtvec", 12'h305, 32'h100);
      rd("arst_mstatus", 12'h300, 32'h1800);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/wb_trap_unit.md
Name: wb_trap_unit

Overview:
Write-back-stage consumer of the MEM/WB latch's exception fields (exp_vector_WB, mret_WB, isFlushed) in the RV32I 5-stage core. Owns the machine-mode CSRs. Resolves synchronous exceptions, external interrupts and mret. Drives a registered one-cycle pipeline flush and PC redirect back to IF.

Parameters:
MTVEC_RESET, 32'h0000_0100, reset value of mtvec (direct mode).
INT_SYNC_STAGES, 2, flip-flop depth of the ext_int synchroniser (min 2).

Ports:
clk  in  1  core clock; all state changes on rising edge
rst  in  1  asynchronous, active-high reset
EN  in  1  pipeline enable, same signal as the MEM/WB latch; state advances only when 1
PCurrent_WB  in  32  PC of the WB instruction
IR_WB  in  32  WB instruction word
ALUO_WB  in  32  effective address for load/store faults
exp_vector_WB  in  4  [3] illegal inst, [2] ecall, [1] load fault, [0] store fault
mret_WB  in  1  WB instruction is mret
isFlushed  in  1  WB slot holds a flushed bubble
csr_op_WB  in  2  00 none, 01 write, 10 set, 11 clear
csr_addr_WB  in  12  CSR address
csr_wdata_WB  in  32  rs1/zimm operand
ext_int  in  1  asynchronous external interrupt request
csr_rdata  out  32  combinational read of csr_addr_WB (0 if unmapped)
wb_kill  out  1  combinational; suppress RegWrite of the WB instruction
flush_all  out  1  registered; flush IF..MEM for one cycle
redirect_valid  out  1  registered; load redirect_pc into PC
redirect_pc  out  32  registered target PC

Behaviour:
- Reset: mstatus=0, mie=0, mtvec=MTVEC_RESET, mepc=mcause=mtval=mscratch=0. Synchroniser cleared. State=S_IDLE. flush_all=0, redirect_valid=0, redirect_pc=0.
- CSR map: mstatus 0x300 (MIE[3], MPIE[7], MPP[12:11] reads 2'b11, other bits read 0); mie 0x304 (MEIE[11] only); mtvec 0x305 ([1:0] forced 0); mscratch 0x340; mepc 0x341 ([1:0] forced 0); mcause 0x342; mtval 0x343; mip 0x344 (MEIP[11] = synchronised ext_int, read-only).
- Writes to unmapped or read-only CSRs are ignored.
- WB slot is valid when EN=1, isFlushed=0 and state=S_IDLE.
- Priority within a valid slot, one event per cycle:
  1. Exception (any exp_vector bit).
  2. Interrupt: mstatus.MIE & mie.MEIE & synced int.
  3. mret.
  4. CSR op.
- Exception cause, priority illegal > ecall > load > store:
  - illegal: mcause=2, mtval=IR_WB
  - ecall: mcause=11, mtval=0
  - load fault: mcause=5, mtval=ALUO_WB
  - store fault: mcause=7, mtval=ALUO_WB
- Exception actions: mepc=PCurrent_WB; MPIE=MIE; MIE=0; wb_kill=1; any CSR op in the same slot is discarded.
- Interrupt: taken on a valid WB instruction with no exception; that instruction is killed (wb_kill=1). mepc=PCurrent_WB, mcause=32'h8000_000B, mtval=0, MPIE=MIE, MIE=0.
- mret: MIE=MPIE, MPIE=1; target=mepc. The value is sampled before any same-edge update.
- On trap or mret at edge T: next edge sets flush_all=1, redirect_valid=1, redirect_pc=mtvec (trap) or mepc (mret). State goes to S_REDIRECT.
- S_REDIRECT: lasts exactly one cycle with outputs high. WB inputs ignored, no CSR writes. Then S_IDLE with outputs low.
- EN=0 holds all state and outputs. rst mid-redirect returns to S_IDLE immediately with outputs low.
- CSR set/clear: new = old | wdata, or old & ~wdata. Write mask applied after the op. csr_rdata returns the pre-write value.

Decomposition:
- Shared package trap_pkg holds:
  - CSR address constants
  - mcause codes (2, 5, 7, 11, 0x8000000B)
  - exp_vector bit indices
  - csr_op encodings
  - state enum S_IDLE / S_REDIRECT
- One natural sub-module: m_csr_file (register storage, write masks, read mux, mip view). The trap FSM and priority logic stay in wb_trap_unit.

Test Plan:
1. Reset; then read 0x305 -> csr_rdata=0x100; redirect_valid=0, flush_all=0.
2. mtvec←0x200. Slot: exp_vector=4'b0100, PC=0x1000 -> mepc=0x1000, mcause=11, MIE=0; next cycle redirect_pc=0x200 with flush_all=1 for one cycle only.
3. exp_vector=4'b1010, IR=0xFFFFFFFF -> mcause=2, mtval=0xFFFFFFFF (illegal wins over load fault); the same-slot csr write to mscratch does not occur.
4. mstatus=0x8, mie=0x800, ext_int=1; after sync, valid slot PC=0x2000 -> wb_kill=1, mepc=0x2000, mcause=0x8000000B, redirect_pc=mtvec.
5. mepc=0x1004, MPIE=1, mret_WB=1 -> redirect_pc=0x1004, mstatus reads 0x1888.
6. isFlushed=1 with exp_vector=4'b0001 -> no trap. EN=0 during S_REDIRECT -> flush_all held high until EN returns. rst asserted then -> outputs 0 asynchronously.
